ram_strcpy_ctrl: RTL and testbench

Copy engine and access arbiter for the 1024 x 10 single-port scratch RAM (asynchronous read, synchronous write). It walks a null-terminated string starting at a source address and copies it word by word to a destination address. It shares the single RAM port with a CPU-side requester using alternating priority under contention. It sits between the CPU bus and the RAM and owns all RAM port signals.

---
 rtl/ram_strcpy_ctrl_if.sv | 32 +++
 rtl/ram_strcpy_ctrl.sv | 146 ++++++++++++++
 tb/tb_ram_strcpy_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_strcpy_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_strcpy_ctrl_if
// CPU-side request bus into the scratch-RAM copy engine / arbiter.
//   cpu_req    CPU wants the RAM port this cycle
//   cpu_we     CPU write enable
//   cpu_addr   CPU word address
//   cpu_wdata  CPU write data
//   cpu_gnt    combinational grant; the CPU access takes effect this cycle
//   cpu_rdata  RAM read data, passed straight through every cycle
// master = CPU side, slave = ram_strcpy_ctrl side.
// ---------------------------------------------------------------------------
interface ram_strcpy_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 10
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata
    );
endinterface

// File: rtl/ram_strcpy_ctrl.sv
// ---------------------------------------------------------------------------
// ram_strcpy_ctrl
// Copies a null-terminated string inside the single-port scratch RAM
// (async read, sync write) and arbitrates that port against a CPU requester.
// Ports:
//   clk, reset              clock, async active-high reset
//   start                   copy request (only seen in IDLE)
//   src_addr, dst_addr      source / destination start, captured with start
//   busy                    high while reading/writing
//   done                    one-cycle completion pulse
//   err, len                length-cap flag and copied word count
//   bus                     CPU request bus (slave side)
//   ram_we, ram_address,
//   ram_wdata, ram_rdata    RAM port, fully owned by this block
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start
// S_READ  | fetch word src+idx into chr
// S_WRITE | store chr at dst+idx; terminator or length cap ends copy
// S_DONE  | one-cycle done pulse, start ignored
// ---------------------------------------------------------------------------
module ram_strcpy_ctrl #(
    parameter int AW      = 10,
    parameter int DW      = 10,
    parameter int MAX_LEN = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        src_addr,
    input  logic [AW-1:0]        dst_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AW-1:0]        len,
    ram_strcpy_ctrl_if.slave     bus,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_address,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [AW-1:0] MAX_LEN_W = AW'(MAX_LEN);

    state_t        state;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] idx;
    logic [DW-1:0] chr;
    logic          stalled;

    logic          eng_want;
    logic          eng_gnt;
    logic          cpu_gnt;
    logic [AW-1:0] len_next;

    assign eng_want = (state == S_READ) || (state == S_WRITE);
    // stalled remembers that the CPU took the last contended cycle, so the
    // engine wins the next one; the CPU wins the first contended cycle.
    assign cpu_gnt  = bus.cpu_req & (~eng_want | ~stalled);
    assign eng_gnt  = eng_want & ~cpu_gnt;
    assign len_next = len + AW'(1);

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.cpu_rdata = ram_rdata;

    always_comb begin
        ram_address = src + idx;
        ram_wdata   = chr;
        ram_we      = 1'b0;
        if (cpu_gnt) begin
            ram_address = bus.cpu_addr;
            ram_wdata   = bus.cpu_wdata;
            ram_we      = bus.cpu_we;
        end else if (state == S_WRITE) begin
            ram_address = dst + idx;
            ram_we      = eng_gnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            stalled <= 1'b0;
            len     <= '0;
            idx     <= '0;
            chr     <= '0;
            src     <= '0;
            dst     <= '0;
        end else begin
            stalled <= eng_want & cpu_gnt;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src   <= src_addr;
                        dst   <= dst_addr;
                        idx   <= '0;
                        len   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (eng_gnt) begin
                        chr   <= ram_rdata;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (eng_gnt) begin
                        if (chr == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + AW'(1);
                            len <= len_next;
                            if (len_next == MAX_LEN_W) begin
                                // cap reached: abort without writing a terminator
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_READ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_strcpy_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_strcpy_ctrl
// Two DUTs share clock and reset: dut (MAX_LEN 1023) and dut_cap (MAX_LEN 4),
// each with its own behavioural 1024x10 RAM. A word-level forward-copy model
// over a shadow memory supplies the expected RAM image, len, err and latency.
// ---------------------------------------------------------------------------
module tb_ram_strcpy_ctrl;
    localparam int AW = 10;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0, dst_addr = '0;
    logic          busy, done, err;
    logic [AW-1:0] len;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [DW-1:0] mem [1024];

    logic          startc = 1'b0;
    logic [AW-1:0] srcc = '0, dstc = '0;
    logic          busyc, donec, errc;
    logic [AW-1:0] lenc;
    logic          ram_wec;
    logic [AW-1:0] ram_addressc;
    logic [DW-1:0] ram_wdatac, ram_rdatac;
    logic [DW-1:0] memc [1024];

    logic [DW-1:0] model [1024];
    logic [DW-1:0] model_save [1024];

    int n_tests = 0;
    int n_fail  = 0;
    int gnt_bad = 0;
    int done_cnt = 0;
    string word_str = "WafflesAndPancakes";

    ram_strcpy_ctrl_if #(.AW(AW), .DW(DW)) bus ();
    ram_strcpy_ctrl_if #(.AW(AW), .DW(DW)) busc ();

    ram_strcpy_ctrl #(.AW(AW), .DW(DW), .MAX_LEN(1023)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .busy(busy), .done(done), .err(err), .len(len),
        .bus(bus.slave), .ram_we(ram_we), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_strcpy_ctrl #(.AW(AW), .DW(DW), .MAX_LEN(4)) dut_cap (
        .clk(clk), .reset(reset), .start(startc), .src_addr(srcc),
        .dst_addr(dstc), .busy(busyc), .done(donec), .err(errc), .len(lenc),
        .bus(busc.slave), .ram_we(ram_wec), .ram_address(ram_addressc),
        .ram_wdata(ram_wdatac), .ram_rdata(ram_rdatac)
    );

    assign ram_rdata  = mem[ram_address];
    assign ram_rdatac = memc[ram_addressc];
    always @(posedge clk) if (ram_we)  mem[ram_address]   <= ram_wdata;
    always @(posedge clk) if (ram_wec) memc[ram_addressc] <= ram_wdatac;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Reference: forward word copy over the shadow memory.
    function automatic void ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                     input int max_len, output int n, output bit e,
                                     output int words);
        logic [DW-1:0] c;
        n = 0; e = 1'b0; words = 0;
        for (int k = 0; k < 2048; k++) begin
            c = model[10'(int'(s) + n)];
            model[10'(int'(d) + n)] = c;
            if (c == '0) begin
                words = n + 1;
                return;
            end
            n++;
            if (n == max_len) begin
                e = 1'b1;
                words = max_len;
                return;
            end
        end
    endfunction

    function automatic int mem_diff(input bit cap_ram, output int first);
        int cnt = 0;
        first = -1;
        for (int i = 0; i < 1024; i++) begin
            if ((cap_ram ? memc[i] : mem[i]) !== model[i]) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        return cnt;
    endfunction

    // CPU write into both RAMs through the CPU port (both DUTs idle).
    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = v;
        busc.cpu_req = 1'b1; busc.cpu_we = 1'b1; busc.cpu_addr = a; busc.cpu_wdata = v;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        busc.cpu_req = 1'b0; busc.cpu_we = 1'b0;
        model[a] = v;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 18; i++) poke(10'(3 + i), {2'b00, word_str[i]});
        poke(10'd21, 10'd0);
    endtask

    // mode 0: CPU idle; 1: CPU writes 0x3FF to 900.. every cycle; 2: random
    // CPU reads plus spurious start pulses while busy.
    task automatic do_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int mode, output int cyc);
        int wr_k = 0;
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d;
        @(posedge clk); #1;
        start = 1'b0; src_addr = 10'($urandom); dst_addr = 10'($urandom);
        cyc = 0;
        while (done !== 1'b1 && cyc < 10000) begin
            case (mode)
                1: begin
                    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
                    bus.cpu_addr = 10'(900 + wr_k); bus.cpu_wdata = 10'h3FF;
                end
                2: begin
                    bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_we = 1'b0;
                    bus.cpu_addr = 10'($urandom);
                    start = ($urandom_range(0, 5) == 0);
                    src_addr = 10'($urandom); dst_addr = 10'($urandom);
                end
                default: bus.cpu_req = 1'b0;
            endcase
            @(negedge clk);
            if (mode == 1) begin
                if (bus.cpu_gnt !== ((cyc % 2) == 0)) gnt_bad++;
                if (bus.cpu_gnt === 1'b1) begin
                    model[10'(900 + wr_k)] = 10'h3FF;
                    wr_k++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        int fa;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        busc.cpu_req = 1'b0; busc.cpu_we = 1'b0; busc.cpu_addr = '0; busc.cpu_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, done, err, ram_we, bus.cpu_gnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/err/we/gnt=%b required 00000",
                     {busy, done, err, ram_we, bus.cpu_gnt});
        end
        n_tests++;
        if (len !== '0) begin
            n_fail++;
            $display("FAIL reset_len: got %0d required 0", len);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) poke(10'(i), 10'($urandom));
        n_tests++;
        if (mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL idle_cpu_write: first bad addr %0d got %h required %h",
                     fa, mem[fa], model[fa]);
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd5;
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.cpu_rdata !== model[5] || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cpu_read: gnt=%b rdata=%h we=%b required 1 %h 0",
                     bus.cpu_gnt, bus.cpu_rdata, ram_we, model[5]);
        end
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_len_cap();
        int cyc, n, words, fa;
        bit e;
        load_pattern();
        for (int i = 600; i < 620; i++) poke(10'(i), 10'h155);
        model_save = model;
        startc = 1'b1; srcc = 10'd3; dstc = 10'd600;
        @(posedge clk); #1;
        startc = 1'b0;
        cyc = 0;
        while (donec !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        ref_copy(10'd3, 10'd600, 4, n, e, words);
        n_tests++;
        if (donec !== 1'b1 || cyc != 2 * words) begin
            n_fail++;
            $display("FAIL cap_latency: done=%b after %0d cycles required %0d",
                     donec, cyc, 2 * words);
        end
        n_tests++;
        if (lenc !== 10'(n) || errc !== e) begin
            n_fail++;
            $display("FAIL cap_len_err: len=%0d err=%b required %0d %b", lenc, errc, n, e);
        end
        n_tests++;
        if (memc[604] !== 10'h155) begin
            n_fail++;
            $display("FAIL cap_no_terminator: ram[604]=%h required 155", memc[604]);
        end
        n_tests++;
        if (mem_diff(1'b1, fa) != 0) begin
            n_fail++;
            $display("FAIL cap_mem: first bad addr %0d got %h required %h",
                     fa, memc[fa], model[fa]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (errc !== 1'b1 || lenc !== 10'(n)) begin
            n_fail++;
            $display("FAIL cap_hold: err=%b len=%0d required 1 %0d", errc, lenc, n);
        end
        model = model_save;
    endtask

    task automatic test_basic();
        int cyc, n, words, fa;
        bit e;
        do_copy(10'd3, 10'd600, 0, cyc);
        ref_copy(10'd3, 10'd600, 1023, n, e, words);
        n_tests++;
        if (done !== 1'b1 || cyc != 2 * words) begin
            n_fail++;
            $display("FAIL basic_latency: done=%b after %0d cycles required %0d",
                     done, cyc, 2 * words);
        end
        n_tests++;
        if (len !== 10'(n) || err !== e || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_len_err: len=%0d err=%b busy=%b required %0d %b 0",
                     len, err, busy, n, e);
        end
        n_tests++;
        if (mem[618] !== 10'd0 || mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL basic_mem: ram[618]=%h first bad addr %0d", mem[618], fa);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b one cycle later required 0", done);
        end
    endtask

    task automatic test_empty();
        int cyc, n, words, fa;
        bit e;
        do_copy(10'd21, 10'd700, 0, cyc);
        ref_copy(10'd21, 10'd700, 1023, n, e, words);
        n_tests++;
        if (done !== 1'b1 || cyc != 2 * words || len !== 10'(n)) begin
            n_fail++;
            $display("FAIL empty: done=%b cycles=%0d len=%0d required 1 %0d %0d",
                     done, cyc, len, 2 * words, n);
        end
        n_tests++;
        if (mem[700] !== 10'd0 || mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL empty_mem: ram[700]=%h first bad addr %0d", mem[700], fa);
        end
    endtask

    task automatic test_contention();
        int cyc, n, words, fa;
        bit e;
        for (int i = 600; i < 620; i++) poke(10'(i), 10'h155);
        gnt_bad = 0;
        do_copy(10'd3, 10'd600, 1, cyc);
        ref_copy(10'd3, 10'd600, 1023, n, e, words);
        n_tests++;
        if (gnt_bad != 0) begin
            n_fail++;
            $display("FAIL contention_alternate: %0d cycles with wrong cpu_gnt, required 0",
                     gnt_bad);
        end
        n_tests++;
        if (done !== 1'b1 || cyc != 4 * words || len !== 10'(n)) begin
            n_fail++;
            $display("FAIL contention_latency: done=%b cycles=%0d len=%0d required 1 %0d %0d",
                     done, cyc, len, 4 * words, n);
        end
        n_tests++;
        if (mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL contention_mem: first bad addr %0d got %h required %h",
                     fa, mem[fa], model[fa]);
        end
    endtask

    task automatic test_wrap();
        int cyc, n, words, fa;
        bit e;
        // source wraps 1023 -> 0
        poke(10'd1022, 10'h041); poke(10'd1023, 10'h042); poke(10'd0, 10'd0);
        do_copy(10'd1022, 10'd500, 0, cyc);
        ref_copy(10'd1022, 10'd500, 1023, n, e, words);
        n_tests++;
        if (len !== 10'(n) || mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL wrap_src: len=%0d required %0d first bad addr %0d", len, n, fa);
        end
        // destination wraps 1023 -> 0
        poke(10'd800, 10'h041); poke(10'd801, 10'h042); poke(10'd802, 10'd0);
        do_copy(10'd800, 10'd1023, 0, cyc);
        ref_copy(10'd800, 10'd1023, 1023, n, e, words);
        n_tests++;
        if (mem[1023] !== 10'h041 || mem[0] !== 10'h042 || mem[1] !== 10'd0 || len !== 10'(n)) begin
            n_fail++;
            $display("FAIL wrap_dst: ram[1023,0,1]=%h %h %h len=%0d required 041 042 000 %0d",
                     mem[1023], mem[0], mem[1], len, n);
        end
        n_tests++;
        if (mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL wrap_mem: first bad addr %0d got %h required %h",
                     fa, mem[fa], model[fa]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, n, words, fa, done_before;
        bit e;
        for (int i = 600; i < 620; i++) poke(10'(i), 10'h155);
        done_before = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; src_addr = 10'd3; dst_addr = 10'd600;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: busy=%b ram_we=%b required 0 0", busy, ram_we);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // eleven cycles after the start edge, five words have been written
        for (int i = 0; i < 5; i++) model[10'(600 + i)] = model[10'(3 + i)];
        n_tests++;
        if (done_cnt != done_before || mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: done pulses %0d required 0, first bad addr %0d",
                     done_cnt - done_before, fa);
        end
        do_copy(10'd3, 10'd600, 0, cyc);
        ref_copy(10'd3, 10'd600, 1023, n, e, words);
        n_tests++;
        if (done !== 1'b1 || cyc != 2 * words || len !== 10'(n) || mem_diff(1'b0, fa) != 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: done=%b cycles=%0d len=%0d required 1 %0d %0d bad addr %0d",
                     done, cyc, len, 2 * words, n, fa);
        end
    endtask

    task automatic test_random();
        int cyc, n, words, fa, slen;
        bit e;
        logic [AW-1:0] s, d;
        for (int it = 0; it < 8; it++) begin
            slen = $urandom_range(0, 24);
            s = 10'($urandom);
            d = (it == 5) ? s + 10'd1 : 10'($urandom);
            for (int i = 0; i < slen; i++) poke(s + 10'(i), 10'($urandom_range(1, 1023)));
            poke(s + 10'(slen), 10'd0);
            do_copy(s, d, 2, cyc);
            ref_copy(s, d, 1023, n, e, words);
            n_tests++;
            if (done !== 1'b1 || len !== 10'(n) || err !== e) begin
                n_fail++;
                $display("FAIL random_%0d: done=%b len=%0d err=%b required 1 %0d %b",
                         it, done, len, err, n, e);
            end
            n_tests++;
            if (mem_diff(1'b0, fa) != 0) begin
                n_fail++;
                $display("FAIL random_mem_%0d: first bad addr %0d got %h required %h",
                         it, fa, mem[fa], model[fa]);
            end
            // start presented during DONE must be dropped
            start = 1'b1; src_addr = 10'($urandom); dst_addr = 10'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL random_start_in_done_%0d: busy=%b done=%b required 0 0",
                         it, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_len_cap();
        test_basic();
        test_empty();
        test_contention();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
